// File: rtl/rnd_sat_stream_if.sv
// Stream bundle for rnd_sat_stream: input beat with its controls, plus the
// saturated output beat and the saturation counter.
interface rnd_sat_stream_if #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int NCH         = 2
);
  logic                     din_valid;
  logic [NCH*IN_WIDTH-1:0]  din;
  logic [SHIFT_WIDTH-1:0]   shift;
  logic [1:0]               mode;
  logic                     clr_cnt;
  logic                     dout_valid;
  logic [NCH*OUT_WIDTH-1:0] dout;
  logic [NCH-1:0]           sat_flag;
  logic [15:0]              sat_cnt;

  modport master (
    output din_valid, din, shift, mode, clr_cnt,
    input  dout_valid, dout, sat_flag, sat_cnt
  );

  modport slave (
    input  din_valid, din, shift, mode, clr_cnt,
    output dout_valid, dout, sat_flag, sat_cnt
  );
endinterface

// File: rtl/rnd_sat_stream.sv
// Multi-channel right-shift, round (floor / half-up / half-even) and saturate, 2-stage pipeline.
// RND_SAT_SYM_EN selects symmetric saturation (MIN = -MAX); undefined gives two's-complement MIN.
module rnd_sat_lane #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en1,
  input  logic                   en2,
  input  logic [IN_WIDTH-1:0]    din,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic [1:0]             mode,
  output logic [OUT_WIDTH-1:0]   dout,
  output logic                   sat,
  output logic                   sat_nxt
);
  localparam int SI = $clog2(IN_WIDTH);
  localparam logic signed [IN_WIDTH:0] MAX_V =
    {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
`ifdef RND_SAT_SYM_EN
  localparam logic signed [IN_WIDTH:0] MIN_V = -MAX_V;
`else
  localparam logic signed [IN_WIDTH:0] MIN_V = ~MAX_V;
`endif

  logic [SI-1:0]              s;
  logic signed [IN_WIDTH:0]   dx, q, r_d, r_q;
  logic [IN_WIDTH-1:0]        mask;
  logic                       guard, sticky, inc;
  logic                       sat_hi, sat_lo, sat_d, sat_q;
  logic [OUT_WIDTH-1:0]       dout_d, dout_q;

  // Stage 1: arithmetic shift plus rounding increment, one bit wider so r never wraps.
  always_comb begin
    if (32'(shift) > 32'(IN_WIDTH-1)) s = SI'(IN_WIDTH-1);
    else                              s = SI'(shift);
    dx     = $signed({din[IN_WIDTH-1], din});
    q      = dx >>> s;
    guard  = 1'b0;
    sticky = 1'b0;
    mask   = '0;
    if (s != '0) begin
      guard  = din[s - SI'(1)];
      mask   = (IN_WIDTH'(1) << (s - SI'(1))) - IN_WIDTH'(1);
      sticky = |(din & mask);
    end
    case (mode)
      2'b00:   inc = 1'b0;
      2'b10:   inc = guard & (sticky | q[0]);
      default: inc = guard;
    endcase
    r_d = en1 ? (q + $signed({{IN_WIDTH{1'b0}}, inc})) : r_q;
  end

  // Stage 2: clamp; dout holds across idle cycles, the flag does not.
  always_comb begin
    sat_hi = r_q > MAX_V;
    sat_lo = r_q < MIN_V;
    dout_d = dout_q;
    sat_d  = 1'b0;
    if (en2) begin
      sat_d = sat_hi | sat_lo;
      if (sat_hi)      dout_d = MAX_V[OUT_WIDTH-1:0];
      else if (sat_lo) dout_d = MIN_V[OUT_WIDTH-1:0];
      else             dout_d = r_q[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      dout_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      dout_q <= dout_d;
      sat_q  <= sat_d;
    end
  end

  assign dout    = dout_q;
  assign sat     = sat_q;
  assign sat_nxt = sat_d;
endmodule

module rnd_sat_stream #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int NCH         = 2
) (
  input logic             clk,
  input logic             rst,
  rnd_sat_stream_if.slave bus
);
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  logic [NCH-1:0]  sat_nxt;
  logic [15:0]     sat_cnt_q, sat_cnt_d;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    rnd_sat_lane #(
      .IN_WIDTH    (IN_WIDTH),
      .OUT_WIDTH   (OUT_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en1     (bus.din_valid),
      .en2     (vld_pipe_q[1]),
      .din     (bus.din[k*IN_WIDTH +: IN_WIDTH]),
      .shift   (bus.shift),
      .mode    (bus.mode),
      .dout    (bus.dout[k*OUT_WIDTH +: OUT_WIDTH]),
      .sat     (bus.sat_flag[k]),
      .sat_nxt (sat_nxt[k])
    );
  end

  // Counter advances with the beat entering the output register; clear wins.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], bus.din_valid};
    sat_cnt_d  = sat_cnt_q;
    if (bus.clr_cnt)                             sat_cnt_d = '0;
    else if ((|sat_nxt) && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      sat_cnt_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign bus.dout_valid = vld_pipe_q[STAGES];
  assign bus.sat_cnt    = sat_cnt_q;
endmodule

// File: tb/tb_rnd_sat_stream.sv
// Bench for rnd_sat_stream: remainder-based rounding model with a cycle compare,
// directed literal cases, randomized streaming, counter saturation and reset.
module tb_rnd_sat_stream;
  localparam int IW = 32, OW = 16, SW = 5, N = 2;
`ifdef RND_SAT_SYM_EN
  localparam logic [OW-1:0] E_MIN  = 16'h8001;
  localparam logic [N-1:0]  E_SH0S = 2'b10;
`else
  localparam logic [OW-1:0] E_MIN  = 16'h8000;
  localparam logic [N-1:0]  E_SH0S = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rnd_sat_stream_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW), .NCH(N)) bus ();
  rnd_sat_stream #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW), .NCH(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Golden result for one channel: {sat, value}, from floor quotient and remainder.
  function automatic logic [OW:0] gold_ch(input logic [IW-1:0] x, input int sh, input logic [1:0] md);
    longint xv, q, rem, half, r, lo, hi;
    int s;
    s    = (sh > IW-1) ? IW-1 : sh;
    xv   = longint'($signed(x));
    q    = xv >>> s;
    rem  = xv - (q <<< s);
    half = (s == 0) ? 0 : (longint'(1) <<< (s-1));
    r    = q;
    if (s > 0) begin
      if ((md == 2'd1 || md == 2'd3) && rem >= half) r = q + 1;
      if (md == 2'd2 && (rem > half || (rem == half && q[0]))) r = q + 1;
    end
    hi = (longint'(1) <<< (OW-1)) - 1;
`ifdef RND_SAT_SYM_EN
    lo = -hi;
`else
    lo = -hi - 1;
`endif
    if (r > hi) return {1'b1, hi[OW-1:0]};
    if (r < lo) return {1'b1, lo[OW-1:0]};
    return {1'b0, r[OW-1:0]};
  endfunction

  // Model: a beat's golden result appears two clocks after it is sampled.
  logic            m1_v = 1'b0, m_v = 1'b0;
  logic [N*OW-1:0] m1_d = '0, m_d = '0;
  logic [N-1:0]    m1_s = '0, m_s = '0;
  logic [15:0]     m_cnt = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m1_v = 1'b0; m_v = 1'b0; m1_d = '0; m_d = '0; m1_s = '0; m_s = '0; m_cnt = '0;
    end else begin
      m_v = m1_v;
      if (m1_v) begin
        m_d = m1_d;
        m_s = m1_s;
      end else begin
        m_s = '0;
      end
      if (bus.clr_cnt) m_cnt = '0;
      else if (m1_v && (|m1_s) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m1_v = bus.din_valid;
      if (bus.din_valid) begin
        for (int k = 0; k < N; k++) begin
          logic [OW:0] g;
          g = gold_ch(bus.din[k*IW +: IW], int'(bus.shift), bus.mode);
          m1_d[k*OW +: OW] = g[OW-1:0];
          m1_s[k] = g[OW];
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("dout_valid", 64'(bus.dout_valid), 64'(m_v));
    check("sat_flag",   64'(bus.sat_flag),   64'(m_s));
    check("sat_cnt",    64'(bus.sat_cnt),    64'(m_cnt));
    check("dout",       64'(bus.dout),       64'(m_d));
  end

  task automatic drive(input logic v, input logic [IW-1:0] c0, input logic [IW-1:0] c1,
                       input logic [SW-1:0] sh, input logic [1:0] md, input logic clr);
    bus.din_valid = v;
    bus.din       = {c1, c0};
    bus.shift     = sh;
    bus.mode      = md;
    bus.clr_cnt   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic beat_chk(input string nm, input logic [IW-1:0] c0, input logic [IW-1:0] c1,
                          input logic [SW-1:0] sh, input logic [1:0] md,
                          input logic [OW-1:0] e0, input logic [OW-1:0] e1, input logic [N-1:0] es);
    drive(1'b1, c0, c1, sh, md, 1'b0);
    check({nm, "_lat"}, 64'(bus.dout_valid), 64'(1'b0));
    drive(1'b0, '0, '0, '0, 2'd0, 1'b0);
    check({nm, "_vld"}, 64'(bus.dout_valid), 64'(1'b1));
    check({nm, "_ch0"}, 64'(bus.dout[OW-1:0]), 64'(e0));
    check({nm, "_ch1"}, 64'(bus.dout[2*OW-1:OW]), 64'(e1));
    check({nm, "_sat"}, 64'(bus.sat_flag), 64'(es));
  endtask

  function automatic logic [IW-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return $urandom >> $urandom_range(0, 31);
      2:       return -($urandom >> $urandom_range(0, 31));
      default: return 32'h80000000 | ($urandom & 32'hFF);
    endcase
  endfunction

  initial begin
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.shift     = '0;
    bus.mode      = 2'd0;
    bus.clr_cnt   = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_vld", 64'(bus.dout_valid), 64'(1'b0));
    check("reset_cnt", 64'(bus.sat_cnt), 64'(16'h0));

    beat_chk("ovf_hu", 32'h7FFFFFFF, 32'h0, 5'd16, 2'd1, 16'h7FFF, 16'h0000, 2'b01);
    check("ovf_cnt", 64'(bus.sat_cnt), 64'(16'd1));
    beat_chk("half_up", 32'h00018000, 32'hFFFE8000, 5'd16, 2'd1, 16'h0002, 16'hFFFF, 2'b00);
    beat_chk("conv_a",  32'h00018000, 32'h00028000, 5'd16, 2'd2, 16'h0002, 16'h0002, 2'b00);
    beat_chk("conv_b",  32'h00028001, 32'h0,        5'd16, 2'd2, 16'h0003, 16'h0000, 2'b00);
    beat_chk("trunc",   32'hFFFE8000, 32'h00018000, 5'd16, 2'd0, 16'hFFFE, 16'h0001, 2'b00);
    for (int md = 0; md < 4; md++)
      beat_chk("shift0", 32'h00001234, 32'hFFFF8000, 5'd0, 2'(md), 16'h1234, E_MIN, E_SH0S);
    beat_chk("min_s8", 32'h80000000, 32'h00000100, 5'd8, 2'd0, E_MIN, 16'h0001, 2'b01);

    repeat (70000) drive(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0, 2'd0, 1'b0);
    check("cnt_hold", 64'(bus.sat_cnt), 64'(16'hFFFF));
    drive(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0, 2'd0, 1'b1);
    check("cnt_clr", 64'(bus.sat_cnt), 64'(16'h0));
    drive(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0, 2'd0, 1'b0);
    check("cnt_after_clr", 64'(bus.sat_cnt), 64'(16'd1));
    drive(1'b0, '0, '0, '0, 2'd0, 1'b0);
    drive(1'b0, '0, '0, '0, 2'd0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [IW-1:0] a, b;
      a = rnd_val();
      b = rnd_val();
      drive(i[0] == 1'b0, a, b, SW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 15) == 0);
    end
    drive(1'b0, '0, '0, '0, 2'd0, 1'b0);
    drive(1'b0, '0, '0, '0, 2'd0, 1'b0);

    drive(1'b1, 32'h00000100, 32'h00000200, 5'd0, 2'd1, 1'b0);
    drive(1'b1, 32'h00000300, 32'h00000400, 5'd0, 2'd1, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_vld_now", 64'(bus.dout_valid), 64'(1'b0));
    bus.din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_idle_vld", 64'(bus.dout_valid), 64'(1'b0));
      check("rst_idle_dout", 64'(bus.dout), 64'(0));
      check("rst_idle_cnt", 64'(bus.sat_cnt), 64'(0));
      check("rst_idle_sat", 64'(bus.sat_flag), 64'(0));
    end
    beat_chk("post_rst", 32'h00018000, 32'h0, 5'd16, 2'd1, 16'h0002, 16'h0000, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rnd_sat_stream.md
# rnd_sat_stream

Streaming multi-channel rounding and saturation stage: it scales each signed channel of an input beat right by a run-time shift and rounds it by a selectable mode. The result is saturated to OUT_WIDTH bits, and saturation events are reported per beat and counted. It sits between wide accumulator/filter outputs and narrower datapath or DAC interfaces. It is the successor to the fixed single-channel round-half-up reducer.

## Interface
- IN_WIDTH, 32, signed input width per channel
- OUT_WIDTH, 16, signed output width per channel (OUT_WIDTH ≤ IN_WIDTH)
- SHIFT_WIDTH, 5, width of shift control
- NCH, 2, channel count; channel k occupies bits [k*W +: W]

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- din_valid  in  1  input beat valid
- din  in  NCH*IN_WIDTH  packed signed input channels
- shift  in  SHIFT_WIDTH  right-shift amount, sampled with din_valid
- mode  in  2  00 truncate (floor), 01 round-half-up, 10 convergent (half-even), 11 treated as 01; sampled with din_valid
- clr_cnt  in  1  synchronous clear of sat_cnt
- dout_valid  out  1  output beat valid
- dout  out  NCH*OUT_WIDTH  packed signed results
- sat_flag  out  NCH  per-channel saturation indicator for the current dout beat
- sat_cnt  out  16  saturating count of beats with any channel saturated

## Operation
- Pipeline of 2 register stages; no backpressure; a new beat is accepted every cycle.
- Stage 1, per channel:
  - effective shift s = min(shift, IN_WIDTH-1).
  - Compute the (IN_WIDTH+1)-bit sign-extended value q = din >>> s.
  - guard = din[s-1]; sticky = OR of din[s-2:0]; both are 0 when s=0.
- Rounding increment:
  - mode 00: 0.
  - mode 01/11: guard.
  - mode 10: guard & (sticky | q[0]).
- r = q + increment, computed at IN_WIDTH+1 bits; no wrap is possible.
- Stage 2, per channel:
  - r > 2^(OUT_WIDTH-1)-1 → dout = MAX, sat_flag=1.
  - r < MIN → dout = MIN, sat_flag=1.
  - otherwise dout = r[OUT_WIDTH-1:0], sat_flag=0.
- dout holds its last value while dout_valid=0. sat_flag is forced to 0 when dout_valid=0.
- sat_cnt:
  - +1 on each dout_valid beat with |sat_flag.
  - Holds at 0xFFFF and does not wrap.
  - clr_cnt loads 0 and has priority over a simultaneous increment.
- Mode or shift changes take effect on the beat they are sampled with. In-flight beats are unaffected.

## Timing
- Latency: din_valid at cycle n → dout_valid at cycle n+2 carrying that beat.
- Back-to-back beats produce back-to-back outputs; gaps are preserved.
- Reset values: dout_valid=0, dout=0, sat_flag=0, sat_cnt=0, all pipeline valids=0.
- Reset mid-operation: pipeline contents are discarded. No output beat appears after release for data accepted before reset.
- clr_cnt has a 1-cycle effect: sat_cnt reads 0 the cycle after clr_cnt is sampled high.

## Configuration
- RND_SAT_SYM_EN defined: symmetric saturation, MIN = -(2^(OUT_WIDTH-1)-1). An input landing exactly at -2^(OUT_WIDTH-1) also saturates, giving dout MIN and sat_flag=1.
- Undefined: two's-complement saturation, MIN = -2^(OUT_WIDTH-1).

## Test plan
Defaults for all cases: IN=32, OUT=16, NCH=2.
- Round-half-up, mode=01, shift=16: ch0=0x00018000 → 0x0002; ch1=0xFFFE8000 → 0xFFFF. sat_flag=00, dout_valid exactly 2 cycles after din_valid.
- Convergent, mode=10, shift=16: 0x00018000 → 0x0002, 0x00028000 → 0x0002, 0x00028001 → 0x0003. Truncate, mode=00: 0xFFFE8000 → 0xFFFE. shift=0: 0x00001234 → 0x1234 in all modes.
- Rounding overflow, mode=01, shift=16: 0x7FFFFFFF → 0x7FFF with sat_flag=1 and sat_cnt=1. shift=8: 0x80000000 → 0x8000 without the macro; with RND_SAT_SYM_EN → 0x8001 and sat_flag=1.
- Counter: 70000 consecutive saturating beats → sat_cnt holds 0xFFFF. clr_cnt together with a saturating beat → sat_cnt=0 next cycle.
- Streaming: alternating valid/idle beats with shift and mode changing every beat → each output matches the golden model for its own sampled controls, with the same gap pattern.
- Reset: assert rst one cycle after two valid beats → dout_valid=0 immediately. No output after release until new input; all outputs read 0.
